// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples the SPI pins in the clk domain, shifts TX FIFO words
// out on miso and queues received words into an RX FIFO for local logic.
module spi_target #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] txData,
    input  logic             txWriteEn,
    output logic             txFull,
    output logic [WIDTH-1:0] rxData,
    input  logic             rxReadEn,
    output logic             rxEmpty,
    output logic             rxOverflow,
    output logic             txUnderrun,
    input  logic             flagClr
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned CNTW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} stateType;

    stateType state, stateNext;

    logic sclkMeta, sclkSync, sclkPrev;
    logic csMeta, csSync, csPrev;
    logic mosiMeta, mosiSync;
    logic sclkRise, sclkFall, csFall, csRise;

    logic [WIDTH-1:0] txShift;
    logic [WIDTH-2:0] rxShift;
    logic [WIDTH-1:0] rxWord;
    logic [CNTW-1:0]  bitCnt;
    logic             reloadPending;
    logic             loadTx, shiftTx, sampleBit, frameDone;

    logic [WIDTH-1:0] txMem [DEPTH];
    logic [WIDTH-1:0] rxMem [DEPTH];
    logic [AW-1:0]    txWr, txRd, rxWr, rxRd;
    logic [CW-1:0]    txCount, rxCount, txCountNext, rxCountNext;
    logic             txEmpty, rxFull, txPush, txPop, rxPush, rxPop;

    // Two-flop synchronisers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {sclkMeta, sclkSync, sclkPrev} <= 3'b000;
            {csMeta, csSync, csPrev}       <= 3'b111;
            {mosiMeta, mosiSync}           <= 2'b00;
        end else begin
            {sclkMeta, sclkSync, sclkPrev} <= {sclk, sclkMeta, sclkSync};
            {csMeta, csSync, csPrev}       <= {cs_n, csMeta, csSync};
            {mosiMeta, mosiSync}           <= {mosi, mosiMeta};
        end
    end

    assign sclkRise = sclkSync & ~sclkPrev;
    assign sclkFall = ~sclkSync & sclkPrev;
    assign csFall   = ~csSync & csPrev;
    assign csRise   = csSync & ~csPrev;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        loadTx    = 1'b0;
        shiftTx   = 1'b0;
        sampleBit = 1'b0;
        case (state)
            IDLE:  if (csFall) stateNext = LOAD;
            LOAD: begin
                loadTx    = 1'b1;
                stateNext = SHIFT;
            end
            SHIFT: begin
                sampleBit = sclkRise;
                if (sclkFall) begin
                    loadTx  = reloadPending;
                    shiftTx = ~reloadPending;
                end
            end
            default: stateNext = IDLE;
        endcase
        // Deselect aborts whatever is in flight
        if (csRise) begin
            stateNext = IDLE;
            loadTx    = 1'b0;
            shiftTx   = 1'b0;
            sampleBit = 1'b0;
        end
    end

    assign frameDone = sampleBit && (bitCnt == CNTW'(WIDTH - 1));
    assign rxWord    = {rxShift, mosiSync};

    always_ff @(posedge clk) begin
        if (rst) begin
            txShift       <= '0;
            rxShift       <= '0;
            bitCnt        <= '0;
            reloadPending <= 1'b0;
            miso          <= 1'b0;
        end else begin
            if (loadTx) begin
                txShift       <= txEmpty ? '0 : txMem[txRd];
                miso          <= ~txEmpty & txMem[txRd][WIDTH-1];
                reloadPending <= 1'b0;
            end else if (shiftTx) begin
                txShift <= txShift << 1;
                miso    <= txShift[WIDTH-2];
            end
            if (state == LOAD) bitCnt <= '0;
            if (sampleBit) begin
                rxShift <= rxWord[WIDTH-2:0];
                bitCnt  <= frameDone ? '0 : bitCnt + CNTW'(1);
                if (frameDone) reloadPending <= 1'b1;
            end
            if (csRise || state == IDLE) begin
                miso          <= 1'b0;
                reloadPending <= 1'b0;
            end
        end
    end

    assign txEmpty     = (txCount == '0);
    assign rxFull      = (rxCount == CW'(DEPTH));
    assign txPush      = txWriteEn & ~txFull;
    assign txPop       = loadTx & ~txEmpty;
    assign rxPop       = rxReadEn & ~rxEmpty;
    assign rxPush      = frameDone & (~rxFull | rxPop);
    assign txCountNext = txCount + CW'(txPush) - CW'(txPop);
    assign rxCountNext = rxCount + CW'(rxPush) - CW'(rxPop);

    always_ff @(posedge clk) begin
        if (txPush) txMem[txWr] <= txData;
        if (rxPush) rxMem[rxWr] <= rxWord;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            txWr    <= '0;
            txRd    <= '0;
            txCount <= '0;
            txFull  <= 1'b0;
            rxWr    <= '0;
            rxRd    <= '0;
            rxCount <= '0;
            rxEmpty <= 1'b1;
            rxData  <= '0;
        end else begin
            if (txPush) txWr <= txWr + AW'(1);
            if (txPop)  txRd <= txRd + AW'(1);
            if (rxPush) rxWr <= rxWr + AW'(1);
            if (rxPop) begin
                rxRd   <= rxRd + AW'(1);
                rxData <= rxMem[rxRd];
            end
            txCount <= txCountNext;
            txFull  <= (txCountNext == CW'(DEPTH));
            rxCount <= rxCountNext;
            rxEmpty <= (rxCountNext == '0);
        end
    end

    // Sticky status; a set in the same cycle beats flagClr
    always_ff @(posedge clk) begin
        if (rst) begin
            txUnderrun <= 1'b0;
            rxOverflow <= 1'b0;
        end else begin
            if (loadTx && txEmpty) txUnderrun <= 1'b1;
            else if (flagClr)      txUnderrun <= 1'b0;
            if (frameDone && rxFull && !rxPop) rxOverflow <= 1'b1;
            else if (flagClr)                  rxOverflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a bit-banged mode-0 controller plus a
// queue-based model of frame/FIFO/flag behaviour.
module tb_spi_target;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi, miso;
    logic [7:0] txData, rxData;
    logic       txWriteEn, txFull, rxReadEn, rxEmpty, rxOverflow, txUnderrun, flagClr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] txQ[$];
    logic [7:0] rxQ[$];
    bit         mUnder, mOver;
    logic [7:0] sendBuf[16];
    logic [7:0] recvBuf[16];
    logic [7:0] expBuf[16];

    spi_target #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .txData(txData), .txWriteEn(txWriteEn), .txFull(txFull),
        .rxData(rxData), .rxReadEn(rxReadEn), .rxEmpty(rxEmpty),
        .rxOverflow(rxOverflow), .txUnderrun(txUnderrun), .flagClr(flagClr)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushTx(input logic [7:0] d);
        txData = d;
        txWriteEn = 1'b1;
        @(negedge clk);
        txWriteEn = 1'b0;
        if (txQ.size() < 8) txQ.push_back(d);
    endtask

    task automatic popRx(output logic [7:0] d);
        rxReadEn = 1'b1;
        @(negedge clk);
        rxReadEn = 1'b0;
        d = rxData;
    endtask

    task automatic pulseClr();
        flagClr = 1'b1;
        @(negedge clk);
        flagClr = 1'b0;
        mUnder = 1'b0;
        mOver = 1'b0;
    endtask

    // Model: each frame takes the next TX word (or zero with underrun) and lands in RX if room
    task automatic modelFrames(input int n);
        for (int k = 0; k < n; k++) begin
            if (txQ.size() > 0) expBuf[k] = txQ.pop_front();
            else begin
                expBuf[k] = 8'h00;
                mUnder = 1'b1;
            end
            if (rxQ.size() < 8) rxQ.push_back(sendBuf[k]);
            else mOver = 1'b1;
        end
    endtask

    // n back-to-back frames on one CS; CS rises together with the final SCLK fall
    task automatic runFrames(input int n);
        cs_n = 1'b0;
        cyc(4);
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                mosi = sendBuf[k][i];
                cyc(H);
                recvBuf[k][i] = miso;
                sclk = 1'b1;
                cyc(H);
                sclk = 1'b0;
                if (k == n - 1 && i == 0) cs_n = 1'b1;
            end
        end
        cyc(8);
    endtask

    task automatic partialFrame(input int bits);
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < bits; i++) begin
            mosi = 1'($urandom);
            cyc(H);
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
        end
        cyc(H);
        cs_n = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso got %b want 0", miso); end
        vectors++; if (rxData !== 8'h00) begin miscompares++; $display("FAIL reset_rxData got %h want 00", rxData); end
        vectors++; if (txFull !== 1'b0) begin miscompares++; $display("FAIL reset_txFull got %b want 0", txFull); end
        vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL reset_rxEmpty got %b want 1", rxEmpty); end
        vectors++; if (rxOverflow !== 1'b0) begin miscompares++; $display("FAIL reset_rxOverflow got %b want 0", rxOverflow); end
        vectors++; if (txUnderrun !== 1'b0) begin miscompares++; $display("FAIL reset_txUnderrun got %b want 0", txUnderrun); end
    endtask

    task automatic test_single();
        logic [7:0] got, exp;
        pushTx(8'hA5);
        sendBuf[0] = 8'h3C;
        modelFrames(1);
        runFrames(1);
        vectors++; if (recvBuf[0] !== expBuf[0]) begin miscompares++; $display("FAIL single_miso got %h want %h", recvBuf[0], expBuf[0]); end
        vectors++; if (rxEmpty !== 1'b0) begin miscompares++; $display("FAIL single_rxEmpty got %b want 0", rxEmpty); end
        popRx(got);
        exp = rxQ.pop_front();
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL single_rxData got %h want %h", got, exp); end
        vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL single_rxEmpty_after got %b want 1", rxEmpty); end
        popRx(got);
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL single_pop_empty_hold got %h want %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        for (int k = 1; k <= 8; k++) pushTx(8'(k));
        vectors++; if (txFull !== (txQ.size() == 8)) begin miscompares++; $display("FAIL b2b_txFull got %b want 1", txFull); end
        pushTx(8'h99);
        for (int k = 0; k < 8; k++) sendBuf[k] = 8'hF0 + 8'(k);
        modelFrames(8);
        runFrames(8);
        for (int k = 0; k < 8; k++) begin
            vectors++; if (recvBuf[k] !== expBuf[k]) begin miscompares++; $display("FAIL b2b_miso[%0d] got %h want %h", k, recvBuf[k], expBuf[k]); end
        end
        for (int k = 0; k < 8; k++) begin
            popRx(got);
            exp = rxQ.pop_front();
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL b2b_rx[%0d] got %h want %h", k, got, exp); end
        end
        vectors++; if (rxOverflow !== mOver) begin miscompares++; $display("FAIL b2b_rxOverflow got %b want %b", rxOverflow, mOver); end
        vectors++; if (txUnderrun !== mUnder) begin miscompares++; $display("FAIL b2b_txUnderrun got %b want %b", txUnderrun, mUnder); end
    endtask

    task automatic test_underrun();
        logic [7:0] got, exp;
        sendBuf[0] = 8'h11;
        modelFrames(1);
        runFrames(1);
        vectors++; if (recvBuf[0] !== expBuf[0]) begin miscompares++; $display("FAIL underrun_miso got %h want %h", recvBuf[0], expBuf[0]); end
        vectors++; if (txUnderrun !== mUnder) begin miscompares++; $display("FAIL underrun_flag got %b want %b", txUnderrun, mUnder); end
        popRx(got);
        exp = rxQ.pop_front();
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL underrun_rxData got %h want %h", got, exp); end
        pulseClr();
        vectors++; if (txUnderrun !== mUnder) begin miscompares++; $display("FAIL underrun_clr got %b want %b", txUnderrun, mUnder); end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        for (int k = 0; k < 8; k++) sendBuf[k] = 8'($urandom);
        modelFrames(8);
        runFrames(8);
        sendBuf[0] = 8'hEE;
        modelFrames(1);
        runFrames(1);
        vectors++; if (rxOverflow !== mOver) begin miscompares++; $display("FAIL ovf_flag got %b want %b", rxOverflow, mOver); end
        for (int k = 0; k < 8; k++) begin
            popRx(got);
            exp = rxQ.pop_front();
            vectors++; if (got !== exp) begin miscompares++; $display("FAIL ovf_rx[%0d] got %h want %h", k, got, exp); end
        end
        vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL ovf_rxEmpty got %b want 1", rxEmpty); end
        pulseClr();
        vectors++; if (rxOverflow !== mOver) begin miscompares++; $display("FAIL ovf_clr got %b want %b", rxOverflow, mOver); end
    endtask

    task automatic test_abort();
        logic [7:0] got, exp;
        pushTx(8'($urandom));
        pushTx(8'($urandom));
        partialFrame(4);
        void'(txQ.pop_front());
        sendBuf[0] = 8'h5A;
        modelFrames(1);
        runFrames(1);
        vectors++; if (recvBuf[0] !== expBuf[0]) begin miscompares++; $display("FAIL abort_miso got %h want %h", recvBuf[0], expBuf[0]); end
        popRx(got);
        exp = rxQ.pop_front();
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL abort_rxData got %h want %h", got, exp); end
        vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL abort_rxEmpty got %b want 1", rxEmpty); end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        int n, p;
        for (int r = 0; r < 6; r++) begin
            pulseClr();
            p = int'($urandom_range(0, 3));
            for (int j = 0; j < p; j++) pushTx(8'($urandom));
            vectors++; if (txFull !== (txQ.size() == 8)) begin miscompares++; $display("FAIL rand%0d_txFull got %b want %b", r, txFull, txQ.size() == 8); end
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) sendBuf[k] = 8'($urandom);
            modelFrames(n);
            runFrames(n);
            for (int k = 0; k < n; k++) begin
                vectors++; if (recvBuf[k] !== expBuf[k]) begin miscompares++; $display("FAIL rand%0d_miso[%0d] got %h want %h", r, k, recvBuf[k], expBuf[k]); end
            end
            vectors++; if (txUnderrun !== mUnder) begin miscompares++; $display("FAIL rand%0d_txUnderrun got %b want %b", r, txUnderrun, mUnder); end
            vectors++; if (rxOverflow !== mOver) begin miscompares++; $display("FAIL rand%0d_rxOverflow got %b want %b", r, rxOverflow, mOver); end
            while (rxQ.size() > 0) begin
                popRx(got);
                exp = rxQ.pop_front();
                vectors++; if (got !== exp) begin miscompares++; $display("FAIL rand%0d_rx got %h want %h", r, got, exp); end
            end
            vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL rand%0d_rxEmpty got %b want 1", r, rxEmpty); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, exp;
        for (int j = 0; j < 3; j++) pushTx(8'($urandom));
        cs_n = 1'b0;
        cyc(4);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'($urandom);
            cyc(H);
            sclk = 1'b1;
            cyc(H);
            sclk = 1'b0;
        end
        cyc(2);
        rst = 1'b1;
        cyc(3);
        cs_n = 1'b1;
        cyc(3);
        rst = 1'b0;
        txQ.delete();
        rxQ.delete();
        mUnder = 1'b0;
        mOver = 1'b0;
        cyc(4);
        vectors++; if (txFull !== 1'b0) begin miscompares++; $display("FAIL rstmid_txFull got %b want 0", txFull); end
        vectors++; if (rxEmpty !== 1'b1) begin miscompares++; $display("FAIL rstmid_rxEmpty got %b want 1", rxEmpty); end
        vectors++; if (miso !== 1'b0) begin miscompares++; $display("FAIL rstmid_miso got %b want 0", miso); end
        sendBuf[0] = 8'($urandom);
        modelFrames(1);
        runFrames(1);
        vectors++; if (recvBuf[0] !== expBuf[0]) begin miscompares++; $display("FAIL rstmid_frame_miso got %h want %h", recvBuf[0], expBuf[0]); end
        vectors++; if (txUnderrun !== mUnder) begin miscompares++; $display("FAIL rstmid_txUnderrun got %b want %b", txUnderrun, mUnder); end
        popRx(got);
        exp = rxQ.pop_front();
        vectors++; if (got !== exp) begin miscompares++; $display("FAIL rstmid_rxData got %h want %h", got, exp); end
    endtask

    initial begin
        rst = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        txData = 8'h00;
        txWriteEn = 1'b0;
        rxReadEn = 1'b0;
        flagClr = 1'b0;
        mUnder = 1'b0;
        mOver = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_overflow();
        test_abort();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
